// File: rtl/bbox_pkg.sv
// Shared types for the bounding-box tracker: emitter states, box record, message length.
// BBOX_PIXCOUNT_EN adds a per-class pixel-count word to each snapshot message.
package bbox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CTR,
    ST_SIZE
`ifdef BBOX_PIXCOUNT_EN
    , ST_CNT
`endif
  } emit_state_e;

  localparam logic [15:0] HDR_MAGIC = 16'h4242;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
    logic [15:0] top;
    logic [15:0] bottom;
    logic        valid;
  } box_t;

  function automatic int msg_len(input int n_class);
`ifdef BBOX_PIXCOUNT_EN
    return 1 + 3 * n_class;
`else
    return 1 + 2 * n_class;
`endif
  endfunction

endpackage

// File: rtl/bbox_accum.sv
// Per-class extent/count accumulator with frame-start clear and end-of-frame latch.
module bbox_accum
  import bbox_pkg::*;
#(
  parameter int COORD_W = 11,
  parameter int CNT_W   = 20,
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480,
  parameter int MIN_PIX = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               upd,
  input  logic               lat,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] nxt_left,
  output logic [COORD_W-1:0] nxt_right,
  output logic [COORD_W-1:0] nxt_top,
  output logic [COORD_W-1:0] nxt_bottom,
  output logic [CNT_W-1:0]   nxt_count,
  output logic               nxt_valid,
  output logic [COORD_W-1:0] lat_left,
  output logic [COORD_W-1:0] lat_right,
  output logic [COORD_W-1:0] lat_top,
  output logic [COORD_W-1:0] lat_bottom,
  output logic               lat_valid
);

  logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
  logic [CNT_W-1:0]   count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Running values including the current beat, so the eop pixel lands in the latch.
  always_comb begin
    nxt_left   = (upd && x < min_x) ? x : min_x;
    nxt_right  = (upd && x > max_x) ? x : max_x;
    nxt_top    = (upd && y < min_y) ? y : min_y;
    nxt_bottom = (upd && y > max_y) ? y : max_y;
    nxt_count  = upd ? sat_inc(count) : count;
    nxt_valid  = (nxt_count >= CNT_W'(MIN_PIX));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      min_x <= COORD_W'(IMAGE_W - 1);
      min_y <= COORD_W'(IMAGE_H - 1);
      max_x <= '0;
      max_y <= '0;
      count <= '0;
    end else begin
      min_x <= nxt_left;
      max_x <= nxt_right;
      min_y <= nxt_top;
      max_y <= nxt_bottom;
      count <= nxt_count;
    end
    if (lat) begin
      lat_left   <= nxt_left;
      lat_right  <= nxt_right;
      lat_top    <= nxt_top;
      lat_bottom <= nxt_bottom;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      lat_valid <= 1'b0;
    else if (lat)
      lat_valid <= nxt_valid;
  end

endmodule

// File: rtl/bbox_tracker.sv
// Multi-class bounding-box tracker: per-frame extents, outline overlay, periodic snapshot messages.
// Define BBOX_PIXCOUNT_EN to append a pixel-count word after each class SIZE word.
module bbox_tracker
  import bbox_pkg::*;
#(
  parameter int N_CLASS      = 5,
  parameter int COORD_W      = 11,
  parameter int CNT_W        = 20,
  parameter int IMAGE_W      = 640,
  parameter int IMAGE_H      = 480,
  parameter int MSG_INTERVAL = 20,
  parameter int MIN_PIX      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_valid,
  input  logic               pix_sop,
  input  logic               pix_eop,
  input  logic               pix_video,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [N_CLASS-1:0] pix_class,
  input  logic [COORD_W-1:0] ov_x,
  input  logic [COORD_W-1:0] ov_y,
  output logic [N_CLASS-1:0] ov_hit,
  output logic               msg_valid,
  input  logic               msg_ready,
  output logic [31:0]        msg_data,
  output logic               busy
);

  localparam int CLS_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int FC_W  = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;

  logic               pix_beat, latch, found;
  logic [N_CLASS-1:0] cls_sel;

  assign pix_beat = pix_valid & ~pix_sop & pix_video;
  assign latch    = pix_valid & pix_eop & pix_video & ~pix_sop;

  always_comb begin
    cls_sel = '0;
    found   = 1'b0;
    for (int k = 0; k < N_CLASS; k++) begin
      cls_sel[k] = pix_class[k] & ~found;
      found      = found | pix_class[k];
    end
  end

  logic [COORD_W-1:0] nxt_l [N_CLASS];
  logic [COORD_W-1:0] nxt_r [N_CLASS];
  logic [COORD_W-1:0] nxt_t [N_CLASS];
  logic [COORD_W-1:0] nxt_b [N_CLASS];
  logic [COORD_W-1:0] lat_l [N_CLASS];
  logic [COORD_W-1:0] lat_r [N_CLASS];
  logic [COORD_W-1:0] lat_t [N_CLASS];
  logic [COORD_W-1:0] lat_b [N_CLASS];
  logic [N_CLASS-1:0] nxt_v, lat_v;
`ifdef BBOX_PIXCOUNT_EN
  logic [CNT_W-1:0]   nxt_cnt  [N_CLASS];
  logic [CNT_W-1:0]   emit_cnt [N_CLASS];
`else
  logic [CNT_W-1:0]   unused_cnt [N_CLASS];
`endif

  for (genvar g = 0; g < N_CLASS; g++) begin : g_acc
    bbox_accum #(
      .COORD_W(COORD_W), .CNT_W(CNT_W), .IMAGE_W(IMAGE_W),
      .IMAGE_H(IMAGE_H), .MIN_PIX(MIN_PIX)
    ) u_acc (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (pix_valid & pix_sop),
      .upd        (pix_beat & cls_sel[g]),
      .lat        (latch),
      .x          (pix_x),
      .y          (pix_y),
      .nxt_left   (nxt_l[g]),
      .nxt_right  (nxt_r[g]),
      .nxt_top    (nxt_t[g]),
      .nxt_bottom (nxt_b[g]),
`ifdef BBOX_PIXCOUNT_EN
      .nxt_count  (nxt_cnt[g]),
`else
      .nxt_count  (unused_cnt[g]),
`endif
      .nxt_valid  (nxt_v[g]),
      .lat_left   (lat_l[g]),
      .lat_right  (lat_r[g]),
      .lat_top    (lat_t[g]),
      .lat_bottom (lat_b[g]),
      .lat_valid  (lat_v[g])
    );
  end

  always_comb begin
    ov_hit = '0;
    for (int k = 0; k < N_CLASS; k++)
      ov_hit[k] = lat_v[k] && ov_x >= lat_l[k] && ov_x <= lat_r[k] &&
                  ov_y >= lat_t[k] && ov_y <= lat_b[k] &&
                  (ov_x == lat_l[k] || ov_x == lat_r[k] ||
                   ov_y == lat_t[k] || ov_y == lat_b[k]);
  end

  emit_state_e      state, state_n;
  logic [CLS_W-1:0] cls, cls_n;
  logic [7:0]       seq;
  logic [FC_W-1:0]  frame_cnt;
  logic             trigger, last_cls;
  box_t             emit_box [N_CLASS];
  box_t             cur;
  logic [16:0]      cx_sum, cy_sum;

  assign trigger  = latch && (frame_cnt == '0) && (state == ST_IDLE);
  assign last_cls = (cls == CLS_W'(N_CLASS - 1));

  // Snapshot stage: emit registers are only written when a message starts.
  always_ff @(posedge clk) begin
    if (trigger) begin
      for (int k = 0; k < N_CLASS; k++) begin
        emit_box[k].left   <= 16'(nxt_l[k]);
        emit_box[k].right  <= 16'(nxt_r[k]);
        emit_box[k].top    <= 16'(nxt_t[k]);
        emit_box[k].bottom <= 16'(nxt_b[k]);
        emit_box[k].valid  <= nxt_v[k];
`ifdef BBOX_PIXCOUNT_EN
        emit_cnt[k]        <= nxt_cnt[k];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cls       <= '0;
      seq       <= '0;
      frame_cnt <= FC_W'(MSG_INTERVAL - 1);
    end else begin
      state <= state_n;
      cls   <= cls_n;
      if (state == ST_HDR && msg_ready)
        seq <= seq + 8'd1;
      if (latch) begin
        if (frame_cnt != '0)
          frame_cnt <= frame_cnt - FC_W'(1);
        else if (state == ST_IDLE)
          frame_cnt <= FC_W'(MSG_INTERVAL - 1);
      end
    end
  end

  always_comb begin
    state_n   = state;
    cls_n     = cls;
    msg_valid = (state != ST_IDLE);
    busy      = (state != ST_IDLE);
    msg_data  = '0;
    cur       = emit_box[cls];
    cx_sum    = {1'b0, cur.left} + {1'b0, cur.right};
    cy_sum    = {1'b0, cur.top} + {1'b0, cur.bottom};
    case (state)
      ST_IDLE: if (trigger) begin
        state_n = ST_HDR;
        cls_n   = '0;
      end
      ST_HDR: begin
        msg_data = {HDR_MAGIC, 8'(N_CLASS), seq};
        if (msg_ready) state_n = ST_CTR;
      end
      ST_CTR: begin
        if (cur.valid) msg_data = {cx_sum[16:1], cy_sum[16:1]};
        if (msg_ready) state_n = ST_SIZE;
      end
      ST_SIZE: begin
        if (cur.valid) msg_data = {cur.bottom - cur.top, cur.right - cur.left};
`ifdef BBOX_PIXCOUNT_EN
        if (msg_ready) state_n = ST_CNT;
      end
      ST_CNT: begin
        msg_data = 32'(emit_cnt[cls]);
`endif
        if (msg_ready) begin
          if (last_cls) state_n = ST_IDLE;
          else begin
            state_n = ST_CTR;
            cls_n   = cls + CLS_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bbox_tracker.sv
// Directed bench for bbox_tracker (N_CLASS=5, MSG_INTERVAL=1); follows BBOX_PIXCOUNT_EN if defined.
module tb_bbox_tracker;

`ifdef BBOX_PIXCOUNT_EN
  localparam int MLEN      = 16;
  localparam int STALL_IDX = 10;
`else
  localparam int MLEN      = 11;
  localparam int STALL_IDX = 7;
`endif

  logic        clk = 1'b0;
  logic        reset_n, pix_valid, pix_sop, pix_eop, pix_video, msg_ready;
  logic [10:0] pix_x, pix_y, ov_x, ov_y;
  logic [4:0]  pix_class, ov_hit;
  logic        msg_valid, busy;
  logic [31:0] msg_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_ctr [5];
  logic [31:0] exp_size [5];
  logic [31:0] exp_cnt [5];
  logic [31:0] exp_w [16];

  always #5 clk = ~clk;

  bbox_tracker #(
    .N_CLASS(5), .COORD_W(11), .CNT_W(20), .IMAGE_W(640), .IMAGE_H(480),
    .MSG_INTERVAL(1), .MIN_PIX(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sop(pix_sop),
    .pix_eop(pix_eop), .pix_video(pix_video), .pix_x(pix_x), .pix_y(pix_y),
    .pix_class(pix_class), .ov_x(ov_x), .ov_y(ov_y), .ov_hit(ov_hit),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic beat(input logic sop, input logic eop, input logic video,
                      input int x, input int y, input logic [4:0] c);
    pix_valid = 1'b1; pix_sop = sop; pix_eop = eop; pix_video = video;
    pix_x = 11'(x); pix_y = 11'(y); pix_class = c;
    step();
    pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0;
  endtask

  task automatic pixels(input int n, input int x, input int y, input logic [4:0] c);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b1, x, y, c);
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 5; k++) begin
      exp_ctr[k] = '0; exp_size[k] = '0; exp_cnt[k] = '0;
    end
  endtask

  task automatic build_msg(input logic [7:0] s);
    int n;
    exp_w[0] = {16'h4242, 8'd5, s};
    n = 1;
    for (int k = 0; k < 5; k++) begin
      exp_w[n] = exp_ctr[k];  n = n + 1;
      exp_w[n] = exp_size[k]; n = n + 1;
`ifdef BBOX_PIXCOUNT_EN
      exp_w[n] = exp_cnt[k];  n = n + 1;
`endif
    end
  endtask

  task automatic walk(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      chk($sformatf("word%0d", i), {msg_valid, msg_data}, {1'b1, exp_w[i]});
      step();
    end
  endtask

  task automatic ov(input int x, input int y, input logic [4:0] expv);
    ov_x = 11'(x); ov_y = 11'(y);
    #1;
    chk($sformatf("ov_hit(%0d,%0d)", x, y), 33'(ov_hit), 33'(expv));
  endtask

  initial begin
    reset_n = 1'b0; pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0; pix_video = 1'b0;
    pix_x = '0; pix_y = '0; pix_class = '0; ov_x = '0; ov_y = '0; msg_ready = 1'b1;
    step(); step();
    chk("rst_msg_valid", 33'(msg_valid), 33'(0));
    chk("rst_msg_data", 33'(msg_data), 33'(0));
    chk("rst_busy", 33'(busy), 33'(0));
    ov(10, 20, 5'b00000);
    reset_n = 1'b1;
    step();

    // Frame 1: class 0 box 10..30 x 20..60 (16 px), class 1 only 15 px.
    beat(1'b1, 1'b0, 1'b1, 0, 0, 5'b00000);
    pix_x = '0; pix_y = '0; pix_class = 5'b00001; pix_video = 1'b1; step();
    beat(1'b0, 1'b0, 1'b0, 0, 0, 5'b00001);
    pixels(7, 10, 20, 5'b00001);
    pixels(8, 30, 60, 5'b00001);
    pixels(14, 100, 200, 5'b00010);
    pixels(1, 104, 210, 5'b00110);
    beat(1'b0, 1'b1, 1'b1, 10, 20, 5'b00001);
    clear_exp();
    exp_ctr[0] = 32'h0014_0028; exp_size[0] = 32'h0028_0014;
    exp_cnt[0] = 32'd16; exp_cnt[1] = 32'd15;
    build_msg(8'd0);
    chk("f1_busy", 33'(busy), 33'(1));
    walk(0, MLEN - 1);
    chk("f1_end_valid", 33'(msg_valid), 33'(0));
    ov(10, 20, 5'b00001);
    ov(20, 20, 5'b00001);
    ov(20, 40, 5'b00000);
    ov(30, 60, 5'b00001);
    ov(31, 60, 5'b00000);
    ov(10, 61, 5'b00000);
    ov(100, 200, 5'b00000);
    ov(104, 205, 5'b00000);

    // Frame 2: class 2 is only the corner pixel, eop included.
    beat(1'b1, 1'b0, 1'b1, 0, 0, 5'b00000);
    pixels(15, 639, 479, 5'b00100);
    beat(1'b0, 1'b1, 1'b1, 639, 479, 5'b00100);
    clear_exp();
    exp_ctr[2] = 32'h027F_01DF; exp_cnt[2] = 32'd16;
    build_msg(8'd1);
    walk(0, MLEN - 1);
    chk("f2_end_valid", 33'(msg_valid), 33'(0));
    ov(639, 479, 5'b00100);
    ov(638, 479, 5'b00000);
    ov(10, 20, 5'b00000);

    // Frame 3: class 3 box, last pixel has two class bits; stall mid-message.
    beat(1'b1, 1'b0, 1'b1, 0, 0, 5'b00000);
    pixels(15, 100, 50, 5'b01000);
    beat(1'b0, 1'b1, 1'b1, 200, 150, 5'b11000);
    clear_exp();
    exp_ctr[3] = 32'h0096_0064; exp_size[3] = 32'h0064_0064; exp_cnt[3] = 32'd16;
    build_msg(8'd2);
    walk(0, STALL_IDX - 1);
    msg_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall%0d", c), {msg_valid, msg_data}, {1'b1, exp_w[STALL_IDX]});
      case (c)
        0, 5:    beat(1'b1, 1'b0, 1'b1, 0, 0, 5'b00000);
        1, 2:    beat(1'b0, 1'b0, 1'b1, 1, 1, 5'b10000);
        3:       beat(1'b0, 1'b1, 1'b1, 1, 1, 5'b10000);
        6, 7:    beat(1'b0, 1'b0, 1'b1, 3, 3, 5'b00001);
        8:       beat(1'b0, 1'b1, 1'b1, 3, 3, 5'b00001);
        default: step();
      endcase
    end
    chk("stall_busy", 33'(busy), 33'(1));
    msg_ready = 1'b1;
    walk(STALL_IDX, MLEN - 1);
    chk("f3_end_valid", 33'(msg_valid), 33'(0));
    step();
    chk("no_retrigger_busy", 33'(busy), 33'(0));
    ov(100, 50, 5'b00000);

    // Frame 6: class 4 box 0..2 x 0..4, sequence continues at 3.
    beat(1'b1, 1'b0, 1'b1, 0, 0, 5'b00000);
    pixels(15, 0, 0, 5'b10000);
    beat(1'b0, 1'b1, 1'b1, 2, 4, 5'b10000);
    clear_exp();
    exp_ctr[4] = 32'h0001_0002; exp_size[4] = 32'h0004_0002; exp_cnt[4] = 32'd16;
    build_msg(8'd3);
    walk(0, MLEN - 1);
    chk("f6_end_valid", 33'(msg_valid), 33'(0));
    ov(2, 1, 5'b10000);
    ov(1, 2, 5'b00000);
    ov(1, 4, 5'b10000);

    // Frame 7: reset while the first SIZE word is on the bus.
    beat(1'b1, 1'b0, 1'b1, 0, 0, 5'b00000);
    pixels(15, 10, 20, 5'b00001);
    beat(1'b0, 1'b1, 1'b1, 10, 20, 5'b00001);
    clear_exp();
    exp_ctr[0] = 32'h000A_0014; exp_cnt[0] = 32'd16;
    build_msg(8'd4);
    walk(0, 1);
    reset_n = 1'b0;
    step();
    chk("midrst_valid", 33'(msg_valid), 33'(0));
    chk("midrst_busy", 33'(busy), 33'(0));
    chk("midrst_data", 33'(msg_data), 33'(0));
    reset_n = 1'b1;
    step();
    chk("postrst_busy", 33'(busy), 33'(0));
    ov(10, 20, 5'b00000);

    // Frame 8: same content, sequence restarts at 0.
    beat(1'b1, 1'b0, 1'b1, 0, 0, 5'b00000);
    pixels(15, 10, 20, 5'b00001);
    beat(1'b0, 1'b1, 1'b1, 10, 20, 5'b00001);
    build_msg(8'd0);
    walk(0, MLEN - 1);
    chk("f8_end_valid", 33'(msg_valid), 33'(0));
    ov(10, 20, 5'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bbox_tracker.md
# bbox_tracker

Multi-class bounding-box tracker for the vision pipeline, sitting after colour thresholding.
- Accumulates per-class extent and pixel count over each video frame and latches the boxes at end of frame.
- Provides a rectangle-outline overlay query for the display path.
- Every MSG_INTERVAL frames, emits a snapshot message over a valid/ready word stream for the CPU-side message FIFO.
- Generalises the fixed five-colour tracker: parametrised class count, coordinate width and noise threshold, per-class validity, and backpressure-tolerant emission.

## Interface
Parameters:
- N_CLASS, 5, number of colour classes (1–16)
- COORD_W, 11, coordinate width (≤16)
- CNT_W, 20, pixel-counter width (≤32)
- IMAGE_W, 640, frame width
- IMAGE_H, 480, frame height
- MSG_INTERVAL, 20, frames between messages (≥1)
- MIN_PIX, 16, minimum pixel count for a class box to be valid

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- pix_valid  in  1  pixel/descriptor beat valid
- pix_sop  in  1  start of packet (descriptor beat, not a pixel)
- pix_eop  in  1  last beat of packet
- pix_video  in  1  current packet is video
- pix_x  in  COORD_W  pixel column
- pix_y  in  COORD_W  pixel row
- pix_class  in  N_CLASS  detect bits; lowest set index wins
- ov_x  in  COORD_W  overlay query column
- ov_y  in  COORD_W  overlay query row
- ov_hit  out  N_CLASS  query point lies on the latched outline of class k
- msg_valid  out  1  message word valid
- msg_ready  in  1  consumer accepts word
- msg_data  out  32  message word
- busy  out  1  emitter not IDLE

## Operation
- Pixel beat: pix_valid & ~pix_sop & pix_video. Only the lowest-index set class updates.
  - min_x, max_x, min_y, max_y and count all update.
  - count saturates at 2^CNT_W−1.
- On pix_valid & pix_sop: all accumulators reset.
  - x_min ← IMAGE_W−1, y_min ← IMAGE_H−1, max ← 0, count ← 0.
- On pix_valid & pix_eop & pix_video & ~pix_sop: latch boxes.
  - The latched values include the eop pixel's own contribution.
  - latched_valid[k] = (count_k ≥ MIN_PIX).
  - sop & eop on the same beat is treated as sop only; nothing is latched.
- ov_hit[k] = latched_valid[k] & point inside [left..right]×[top..bottom] & (x ∈ {left,right} or y ∈ {top,bottom}).
- Trigger: each latch decrements frame_cnt.
  - When frame_cnt == 0 and the emitter is IDLE: snapshot the latched boxes into emit registers, reload frame_cnt to MSG_INTERVAL−1, and start the emitter.
  - When frame_cnt == 0 and the emitter is busy: frame_cnt holds at 0 and the trigger retries at the next latch.
- Emitter FSM: IDLE → HDR → {CTR, SIZE[, CNT]} per class k = 0..N_CLASS−1 → IDLE. It advances only on msg_valid & msg_ready.
  - HDR word = {8'h42, 8'h42, N_CLASS[7:0], seq[7:0]}. seq increments after HDR and wraps 255→0.
  - CTR word = {cx, cy}, each zero-extended to 16 bits; c = (min+max)>>1, with the sum computed in COORD_W+1 bits.
  - SIZE word = {h = bottom−top, w = right−left}, each 16-bit.
  - An invalid class reports 0 in CTR and SIZE.
- Messages are built only from emit registers, so frames latched mid-emission never corrupt a message.

## Timing
- Reset values:
  - msg_valid 0, msg_data 0, busy 0, ov_hit 0.
  - seq 0, frame_cnt MSG_INTERVAL−1.
  - latched_valid 0, FSM IDLE.
- Accumulator update: registered, 1 cycle after the beat.
- Latched boxes and ov_hit reflect the new frame from the cycle after the eop beat. ov_hit is combinational from ov_x/ov_y and the latched boxes.
- The emitter starts (msg_valid=1, HDR on msg_data) the cycle after the triggering eop beat.
- msg_data is stable while msg_valid & ~msg_ready.
- Under continuous msg_ready, one word per cycle; the last word is followed by msg_valid=0 on the next cycle.
- Reset mid-emission: FSM returns to IDLE and msg_valid falls at that edge. No partial message resumes.

## Configuration
- BBOX_PIXCOUNT_EN defined: a CNT word {zero-extend, count_k} follows each SIZE word. Message length = 1+3·N_CLASS.
- BBOX_PIXCOUNT_EN undefined: no CNT state. Message length = 1+2·N_CLASS. The saturating counters remain, for validity only.

## Structure
- Package bbox_pkg:
  - emitter state enum.
  - HDR magic constant 16'h4242.
  - box struct typedef {left, right, top, bottom, valid}.
  - message-length function of N_CLASS.
- Sub-module bbox_accum, one instance per class via generate: min/max/count accumulation, sop reset, eop latch.
- The top level holds the class-priority select, trigger counter, snapshot registers, emitter FSM and overlay compare.

## Test plan
- One frame, class 0 pixels at (10,20) and (30,60), 16 total, MSG_INTERVAL=1 → HDR 0x42420500, then CTR {20,40}, SIZE {40,20}.
- Class 1 with 15 pixels, MIN_PIX=16 → class 1 CTR=0, SIZE=0, ov_hit[1]=0 for all queries.
- Single pixel with pix_class=5'b00110 → only class 1 updates.
- eop pixel at (639,479) is the sole class-2 pixel (×16 repeats at the same point) → latched box 639/639/479/479.
- msg_ready held low 10 cycles mid-message while two further frames end → msg_data stable; no new trigger until IDLE; the next message's seq is +1.
- reset_n low during SIZE word → next cycle msg_valid=0, busy=0, seq=0. With BBOX_PIXCOUNT_EN, message length is 16 words for N_CLASS=5.
